// File: rtl/vec_pkg.sv
// Shared OP-V encodings, FSM states and lane ALU operations for vec_lane_core.
package vec_pkg;

  localparam logic [6:0] OPC_OPV  = 7'b1010111;
  localparam logic [2:0] F3_OPIVV = 3'b000;
  localparam logic [2:0] F3_OPIVI = 3'b011;

  localparam logic [5:0] F6_VADD = 6'b000000;
  localparam logic [5:0] F6_VSUB = 6'b000010;
  localparam logic [5:0] F6_VAND = 6'b001001;
  localparam logic [5:0] F6_VOR  = 6'b001010;
  localparam logic [5:0] F6_VXOR = 6'b001011;
  localparam logic [5:0] F6_VMV  = 6'b010111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2,
    ST_ILL  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_MOV = 3'd5
  } alu_op_t;

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane integer ALU; a is the vs2 element, b the vs1/immediate operand.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int ELEN = 32
) (
  input  alu_op_t          op,
  input  logic [ELEN-1:0]  a,
  input  logic [ELEN-1:0]  b,
  output logic [ELEN-1:0]  y
);

  always_comb begin
    y = b;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_MOV: y = b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/vec_lane_core.sv
// Multi-lane RVV OP-V integer core: decode, PC, FSM, beat counter and vector register file.
// Optional masking by v0 is enabled with the VEC_MASK_EN macro.
module vec_lane_core
  import vec_pkg::*;
#(
  parameter int ELEN      = 32,
  parameter int VL        = 8,
  parameter int LANES     = 2,
  parameter int NUM_VREGS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          instr_valid,
  input  logic [31:0]                   instr_in,
  output logic                          instr_ready,
  output logic [31:0]                   pc_out,
  output logic                          busy,
  output logic                          retire_valid,
  output logic                          illegal,
  input  logic [$clog2(NUM_VREGS)-1:0]  dbg_vreg,
  input  logic [$clog2(VL)-1:0]         dbg_elem,
  output logic [ELEN-1:0]               dbg_rdata
);

  localparam int RW    = $clog2(NUM_VREGS);
  localparam int EW    = $clog2(VL);
  localparam int BEATS = VL / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (VL % LANES != 0) begin : g_bad_lanes
    $error("vec_lane_core: VL must be a multiple of LANES");
  end

  state_t            state_q;
  logic [31:0]       pc_q;
  logic [BW-1:0]     beat_q;
  logic [ELEN-1:0]   vrf [NUM_VREGS][VL];

  alu_op_t           op_q;
  logic [RW-1:0]     vd_q, vs1_q, vs2_q;
  logic              use_imm_q;
  logic [ELEN-1:0]   imm_q;

  logic              dec_legal;
  alu_op_t           dec_op;
  logic              f6_ok, f3_ok, reg_ok, op_ok, mask_ok;

  wire logic [5:0] f6 = instr_in[31:26];
  wire logic [2:0] f3 = instr_in[14:12];
  wire logic       vm = instr_in[25];

  always_comb begin
    dec_op = ALU_ADD;
    f6_ok  = 1'b1;
    op_ok  = 1'b1;
    case (f6)
      F6_VADD: dec_op = ALU_ADD;
      F6_VSUB: begin dec_op = ALU_SUB; op_ok = (f3 == F3_OPIVV); end
      F6_VAND: dec_op = ALU_AND;
      F6_VOR:  dec_op = ALU_OR;
      F6_VXOR: dec_op = ALU_XOR;
      F6_VMV:  begin dec_op = ALU_MOV; op_ok = (instr_in[24:20] == 5'd0) && vm; end
      default: f6_ok = 1'b0;
    endcase
    f3_ok  = (f3 == F3_OPIVV) || (f3 == F3_OPIVI);
    reg_ok = (int'(instr_in[11:7]) < NUM_VREGS) && (int'(instr_in[24:20]) < NUM_VREGS) &&
             ((f3 != F3_OPIVV) || (int'(instr_in[19:15]) < NUM_VREGS));
`ifdef VEC_MASK_EN
    // v0 is the mask source, so it cannot also be a masked destination
    mask_ok = vm || (instr_in[11:7] != 5'd0);
`else
    mask_ok = vm;
`endif
    dec_legal = (instr_in[6:0] == OPC_OPV) && f3_ok && f6_ok && reg_ok && op_ok && mask_ok;
  end

  logic [EW-1:0]   elem_idx [LANES];
  logic [ELEN-1:0] lane_a   [LANES];
  logic [ELEN-1:0] lane_b   [LANES];
  logic [ELEN-1:0] lane_y   [LANES];
  logic            lane_we  [LANES];

`ifdef VEC_MASK_EN
  logic            vm_q;
  logic [VL-1:0]   v0_bits;

  always_comb begin
    v0_bits = '0;
    for (int i = 0; i < VL; i++) v0_bits[i] = vrf[0][i / ELEN][i % ELEN];
  end
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign elem_idx[l] = EW'(int'(beat_q) * LANES + l);
    assign lane_a[l]   = vrf[vs2_q][elem_idx[l]];
    assign lane_b[l]   = use_imm_q ? imm_q : vrf[vs1_q][elem_idx[l]];
`ifdef VEC_MASK_EN
    assign lane_we[l]  = vm_q | v0_bits[elem_idx[l]];
`else
    assign lane_we[l]  = 1'b1;
`endif

    vec_lane_alu #(.ELEN(ELEN)) u_alu (
      .op (op_q),
      .a  (lane_a[l]),
      .b  (lane_b[l]),
      .y  (lane_y[l])
    );
  end

  // Decoded operands captured at accept; only meaningful while executing
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && instr_valid) begin
      op_q      <= dec_op;
      vd_q      <= instr_in[7 +: RW];
      vs1_q     <= instr_in[15 +: RW];
      vs2_q     <= instr_in[20 +: RW];
      use_imm_q <= (f3 == F3_OPIVI);
      imm_q     <= {{(ELEN-5){instr_in[19]}}, instr_in[19:15]};
`ifdef VEC_MASK_EN
      vm_q      <= vm;
`endif
    end
  end

  // Control and register file; reads of a beat see pre-write values, so overlap is safe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      beat_q  <= '0;
      for (int r = 0; r < NUM_VREGS; r++)
        for (int e = 0; e < VL; e++) vrf[r][e] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            pc_q    <= pc_q + 32'd4;
            beat_q  <= '0;
            state_q <= dec_legal ? ST_EXEC : ST_ILL;
          end
        end
        ST_EXEC: begin
          for (int l = 0; l < LANES; l++)
            if (lane_we[l]) vrf[vd_q][elem_idx[l]] <= lane_y[l];
          if (beat_q == BW'(BEATS - 1)) state_q <= ST_DONE;
          else                          beat_q  <= beat_q + 1'b1;
        end
        ST_DONE: state_q <= ST_IDLE;
        ST_ILL:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign retire_valid = (state_q == ST_DONE);
  assign illegal      = (state_q == ST_ILL);
  assign pc_out       = pc_q;
  assign dbg_rdata    = vrf[dbg_vreg][dbg_elem];

endmodule

// File: tb/tb_vec_lane_core.sv
// Self-checking bench for vec_lane_core: directed program plus random OP-V instructions vs a vector model.
`timescale 1ns/1ps
module tb_vec_lane_core;

  localparam int ELEN = 32;
  localparam int VL   = 8;
  localparam int NV   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic        busy, retire_valid, illegal;
  logic [4:0]  dbg_vreg;
  logic [2:0]  dbg_elem;
  logic [31:0] dbg_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_vrf [NV][VL];
  logic [31:0] pc_ref;

  vec_lane_core #(.ELEN(ELEN), .VL(VL), .LANES(2), .NUM_VREGS(NV)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_in     (instr_in),
    .instr_ready  (instr_ready),
    .pc_out       (pc_out),
    .busy         (busy),
    .retire_valid (retire_valid),
    .illegal      (illegal),
    .dbg_vreg     (dbg_vreg),
    .dbg_elem     (dbg_elem),
    .dbg_rdata    (dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opv(input logic [5:0] f6, input logic vm, input logic [4:0] vs2,
                                      input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd);
    return {f6, vm, vs2, vs1, f3, vd, 7'b1010111};
  endfunction

  function automatic bit model_legal(input logic [31:0] ins);
    logic [5:0] f6;
    logic [2:0] f3;
    f6 = ins[31:26];
    f3 = ins[14:12];
    if (ins[6:0] != 7'b1010111) return 0;
    if (f3 != 3'd0 && f3 != 3'd3) return 0;
    if (!(f6 inside {6'd0, 6'd2, 6'd9, 6'd10, 6'd11, 6'd23})) return 0;
    if (f6 == 6'd2 && f3 == 3'd3) return 0;
    if (f6 == 6'd23 && (ins[24:20] != 5'd0 || !ins[25])) return 0;
    if (!ins[25]) begin
`ifdef VEC_MASK_EN
      if (ins[11:7] == 5'd0) return 0;
`else
      return 0;
`endif
    end
    return 1;
  endfunction

  // Whole-vector semantics: all sources read before the destination is replaced
  task automatic model_apply(input logic [31:0] ins);
    logic [31:0] res [VL];
    logic [31:0] a, b, r;
    int vd, vs1, vs2;
    if (!model_legal(ins)) return;
    vd = int'(ins[11:7]); vs1 = int'(ins[19:15]); vs2 = int'(ins[24:20]);
    for (int i = 0; i < VL; i++) begin
      a = ref_vrf[vs2][i];
      b = (ins[14:12] == 3'd0) ? ref_vrf[vs1][i] : {{27{ins[19]}}, ins[19:15]};
      case (ins[31:26])
        6'd0:    r = a + b;
        6'd2:    r = a - b;
        6'd9:    r = a & b;
        6'd10:   r = a | b;
        6'd11:   r = a ^ b;
        default: r = b;
      endcase
      res[i] = (ins[25] || ref_vrf[0][0][i]) ? r : ref_vrf[vd][i];
    end
    for (int i = 0; i < VL; i++) ref_vrf[vd][i] = res[i];
  endtask

  // Called at #1 after a posedge with the core idle; returns at #1 after a posedge
  task automatic issue(input logic [31:0] ins);
    int ret_at, ill_at, ret_cnt, ill_cnt;
    bit legal;
    chk("ready_before_accept", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr_in    = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_in    = $urandom;
    legal  = model_legal(ins);
    pc_ref = pc_ref + 32'd4;
    model_apply(ins);
    ret_at = -1; ill_at = -1; ret_cnt = 0; ill_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (retire_valid) begin ret_cnt++; ret_at = k; end
      if (illegal)      begin ill_cnt++; ill_at = k; end
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("busy_cleared", {31'd0, busy}, 32'd0);
    if (legal) begin
      chk("retire_cycle", 32'(ret_at), 32'd4);
      chk("retire_count", 32'(ret_cnt), 32'd1);
      chk("no_illegal", 32'(ill_cnt), 32'd0);
    end else begin
      chk("illegal_cycle", 32'(ill_at), 32'd0);
      chk("illegal_count", 32'(ill_cnt), 32'd1);
      chk("no_retire", 32'(ret_cnt), 32'd0);
    end
    chk("pc_out", pc_out, pc_ref);
  endtask

  task automatic rd(input int r, input int e, output logic [31:0] v);
    dbg_vreg = 5'(r);
    dbg_elem = 3'(e);
    @(negedge clk);
    v = dbg_rdata;
  endtask

  task automatic check_reg(input int r);
    logic [31:0] v;
    for (int e = 0; e < VL; e++) begin
      rd(r, e, v);
      chk($sformatf("v%0d[%0d]", r, e), v, ref_vrf[r][e]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] v;
    logic [5:0]  f6_tab [7];
    logic [5:0]  f6;
    logic [2:0]  f3;
    logic [4:0]  vs2;
    logic        vm;
    int          sel, retired;

    f6_tab = '{6'd0, 6'd2, 6'd9, 6'd10, 6'd11, 6'd23, 6'd1};
    rst = 1'b1; instr_valid = 1'b0; instr_in = '0; dbg_vreg = '0; dbg_elem = '0;
    for (int r = 0; r < NV; r++) for (int e = 0; e < VL; e++) ref_vrf[r][e] = '0;
    pc_ref = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    chk("rst_pc", pc_out, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_retire", {31'd0, retire_valid}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    check_reg(1);

    // vmv.v.i v1,5 ; vmv.v.i v2,-3
    issue(opv(6'd23, 1'b1, 5'd0, 5'd5, 3'd3, 5'd1));
    issue(opv(6'd23, 1'b1, 5'd0, 5'b11101, 3'd3, 5'd2));
    rd(1, 7, v); chk("v1_is_5", v, 32'd5);
    rd(2, 0, v); chk("v2_is_m3", v, 32'hFFFF_FFFD);
    @(posedge clk); #1;

    // vadd.vv v3,v1,v2 ; vsub.vv v4,v1,v2
    issue(opv(6'd0, 1'b1, 5'd1, 5'd2, 3'd0, 5'd3));
    issue(opv(6'd2, 1'b1, 5'd1, 5'd2, 3'd0, 5'd4));
    chk("pc_after_4", pc_out, 32'd16);
    rd(3, 5, v); chk("v3_is_2", v, 32'd2);
    rd(4, 6, v); chk("v4_is_8", v, 32'd8);
    @(posedge clk); #1;
    check_reg(3);
    check_reg(4);

    // vxor.vi v1,v1,-1 overlapping destination and source
    issue(opv(6'd11, 1'b1, 5'd1, 5'b11111, 3'd3, 5'd1));
    rd(1, 3, v); chk("v1_xor", v, 32'hFFFF_FFFA);
    @(posedge clk); #1;
    check_reg(1);

    // non-OP-V word
    issue(32'h0000_0013);
    for (int r = 1; r <= 4; r++) check_reg(r);

    // v0 = 0x55 built from immediates, then masked vadd.vv v3,v1,v2
    issue(opv(6'd23, 1'b1, 5'd0, 5'd15, 3'd3, 5'd0));
    for (int i = 0; i < 4; i++) issue(opv(6'd0, 1'b1, 5'd0, 5'd15, 3'd3, 5'd0));
    issue(opv(6'd0, 1'b1, 5'd0, 5'd10, 3'd3, 5'd0));
    rd(0, 0, v); chk("v0_is_55", v, 32'h55);
    @(posedge clk); #1;
    issue(opv(6'd0, 1'b0, 5'd1, 5'd2, 3'd0, 5'd3));
`ifdef VEC_MASK_EN
    rd(3, 0, v); chk("mask_even", v, 32'hFFFF_FFF7);
    rd(3, 1, v); chk("mask_odd", v, 32'd2);
`else
    rd(3, 0, v); chk("nomask_e0", v, 32'd2);
    rd(3, 1, v); chk("nomask_e1", v, 32'd2);
`endif
    @(posedge clk); #1;
    check_reg(3);

    // random instructions over v0..v5
    for (int n = 0; n < 40; n++) begin
      f6  = f6_tab[$urandom_range(0, 6)];
      sel = $urandom_range(0, 5);
      f3  = (sel < 3) ? 3'd0 : (sel < 5) ? 3'd3 : 3'd1;
      vm  = ($urandom_range(0, 3) != 0);
      vs2 = 5'($urandom_range(0, 5));
      if (f6 == 6'd23 && $urandom_range(0, 3) != 0) vs2 = 5'd0;
      sel = $urandom_range(0, 5);
      issue(opv(f6, vm, vs2, 5'($urandom_range(0, 31) % 6), f3, 5'(sel)));
      check_reg(sel);
    end

    // reset asserted during beat 2 of a vadd
    instr_valid = 1'b1;
    instr_in    = opv(6'd0, 1'b1, 5'd1, 5'd2, 3'd0, 5'd5);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    retired = 0;
    for (int k = 0; k < 2; k++) begin
      if (retire_valid) retired++;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (retire_valid || illegal) retired++;
    chk("abort_no_pulse", 32'(retired), 32'd0);
    chk("abort_pc", pc_out, 32'd0);
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int r = 0; r < NV; r++) for (int e = 0; e < VL; e++) ref_vrf[r][e] = '0;
    pc_ref = '0;
    for (int r = 0; r <= 5; r++) check_reg(r);

    // core usable again after the abort
    issue(opv(6'd23, 1'b1, 5'd0, 5'd7, 3'd3, 5'd5));
    check_reg(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
